// File: rtl/shift_out_pkg.sv
// Shared definitions for the shift_out_reg serialiser: FSM state encoding
// and the default frame width.
package shift_out_pkg;

    localparam int unsigned SHIFT_OUT_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_out_state_e;

endpackage : shift_out_pkg

// File: rtl/shift_out_reg_bit_counter.sv
// Frame bit counter for shift_out_reg. Clears on clr, counts on inc, and
// flags the terminal count LAST. Sized by the parent so it never wraps
// within a frame.
module bit_counter #(
    parameter int unsigned     CW   = 4,
    parameter logic [CW-1:0]   LAST = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] count;

    // Count register: reset and clear take priority over increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule : bit_counter

// File: rtl/shift_out_reg.sv
// Parallel-in, serial-out frame transmitter (LSB first).
// Optional feature macro: SHIFT_OUT_PARITY_EN appends one even-parity bit
// (XOR of the captured word) after the data bits.
module shift_out_reg
    import shift_out_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_OUT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

`ifdef SHIFT_OUT_PARITY_EN
    localparam int unsigned FLEN = WIDTH + 1;
`else
    localparam int unsigned FLEN = WIDTH;
`endif
    localparam int unsigned   CW   = $clog2(FLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

    shift_out_state_e state, state_nxt;
    logic [FLEN-1:0]  sreg;
    logic             accept;
    logic             inc;
    logic             tc;

    // The parity bit is stored as the MSB of the frame register so it falls
    // out of bit 0 right after d[WIDTH-1] with no extra muxing.
    logic [FLEN-1:0]  frame;
`ifdef SHIFT_OUT_PARITY_EN
    assign frame = {^d, d};
`else
    assign frame = d;
`endif

    bit_counter #(
        .CW   (CW),
        .LAST (LAST)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .inc (inc),
        .tc  (tc)
    );

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame register: capture on accept, shift right while transmitting.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (accept) begin
            sreg <= frame;
        end else if (inc) begin
            sreg <= {1'b0, sreg[FLEN-1:1]};
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        inc        = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = sreg[0];
                inc        = 1'b1;
                if (tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : shift_out_reg

// File: doc/shift_out_reg.md
SHIFT_OUT_REG -- requirements
Module: shift_out_reg

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 load  input  1  request to capture d and start a frame.
REQ-005 d  input  WIDTH  parallel word to transmit.
REQ-006 ready  output  1  block idle; a load is accepted this cycle.
REQ-007 sout  output  1  serial data bit.
REQ-008 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-011 In IDLE: ready=1, sout_valid=0, sout=0, done=0.
REQ-012 Accept when load=1 and ready=1 at a rising edge: d captured into the shift register, bit counter cleared, next state SHIFT.
REQ-013 load while not in IDLE is ignored, with no effect on the current frame.
REQ-014 In SHIFT: ready=0, sout_valid=1, sout=shift register bit 0, LSB first; the register shifts right by one and the counter increments each cycle.
REQ-015 Latency: in cycle k after the accept edge (k=1..WIDTH), sout=d[k-1].
REQ-016 The FSM SHALL leave SHIFT after FLEN frame bits (FLEN=WIDTH, or WIDTH+1 per REQ-023) and enter DONE.
REQ-017 In DONE: done=1, ready=0, sout_valid=0, sout=0; unconditional transition to IDLE next cycle.
REQ-018 Back-to-back: the earliest next accept is the cycle after DONE, so the frame period is FLEN+2 cycles.
REQ-019 The bit counter SHALL be $clog2(FLEN+1) bits wide and SHALL never wrap within a frame.
REQ-020 d SHALL be sampled only on the accept edge; later changes to d do not affect the frame in flight.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL go to IDLE and clear the shift register and counter; the next cycle shows ready=1 and all other outputs 0.
REQ-022 rst SHALL take priority over load and over any FSM transition, including mid-frame, where it aborts the frame with no done pulse.

Configuration
REQ-023 With macro SHIFT_OUT_PARITY_EN defined, one even-parity bit (XOR of the captured d) SHALL follow d[WIDTH-1] with sout_valid=1, so FLEN=WIDTH+1.
REQ-024 Without SHIFT_OUT_PARITY_EN, FLEN=WIDTH and no parity logic is present.

Structure
REQ-025 A shared package shift_out_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the constant SHIFT_OUT_DEFAULT_WIDTH=8.
REQ-026 The bit counter SHALL be a sub-module bit_counter with inputs clk, rst, clr and inc, a terminal-count output, and the count width as a parameter.

Verification (WIDTH=8)
REQ-027 rst=1 for 2 cycles, then 0 -> ready=1, sout=0, sout_valid=0, done=0.
REQ-028 load=1 with d=8'hA5 for one cycle -> sout in cycles 1..8 = 1,0,1,0,0,1,0,1 with sout_valid=1; done=1 in cycle 9; ready=1 in cycle 10.
REQ-029 With SHIFT_OUT_PARITY_EN defined: d=8'h07 -> bits 1,1,1,0,0,0,0,0 then parity bit 1 in cycle 9; done in cycle 10. d=8'hA5 -> parity bit 0.
REQ-030 load held at 1 continuously with d=8'h01 -> a new frame is accepted every 10 cycles (FLEN+2), and d changes during a frame have no effect.
REQ-031 rst=1 in cycle 4 of an 8'hFF frame -> next cycle ready=1 and sout_valid=0, with no done pulse.
REQ-032 load=1 in the same cycle as rst=1 -> not accepted, block stays in IDLE; a load in the following cycle is accepted.
